// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic ARB_PORT_C = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_s;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] rdata;
  } mem_rsp_s;

endpackage

// File: rtl/dmem_arbiter_prio_starve_arb.sv
// rtl/dmem_arbiter_prio_starve_arb.sv - CPU-priority grant with starvation guard for the debug port
module prio_starve_arb #(
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_valid,
  input  logic d_valid,
  input  logic force_d,
  input  logic clear,
  output logic gnt_c,
  output logic gnt_d
);

  logic [3:0] starve_cnt;
  logic       contested;
  logic       starved;

  // Grant decision: locked mode hands the port to D, otherwise C wins unless D has waited too long
  always_comb begin
    gnt_c     = 1'b0;
    gnt_d     = 1'b0;
    contested = c_valid && d_valid;
    starved   = (starve_cnt == 4'(MAX_STARVE));
    if (force_d) begin
      gnt_d = d_valid;
    end else if (contested) begin
      gnt_d = starved;
      gnt_c = !starved;
    end else begin
      gnt_c = c_valid;
      gnt_d = d_valid;
    end
  end

  // Count consecutive contested CPU wins; any D grant, idle D or lock transition restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (clear || force_d || !d_valid || gnt_d) begin
      starve_cnt <= '0;
    end else if (contested && gnt_c) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with debug lock; DMEM_ARB_PERF_EN adds perf counters
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_lock,
  output logic              d_locked,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_dgrant_cnt
`endif
);

  arb_state_e state;
  arb_state_e state_next;
  logic       gnt_c;
  logic       gnt_d;
  logic       sel_port;
  mem_req_s   c_req;
  mem_req_s   d_req;
  mem_req_s   mem_req;
  mem_rsp_s   c_rsp_q;
  mem_rsp_s   d_rsp_q;

  // Lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OPEN;
    end else begin
      state <= state_next;
    end
  end

  // Lock transitions follow d_lock with one cycle of delay
  always_comb begin
    state_next = state;
    case (state)
      OPEN:    if (d_lock)  state_next = LOCKED;
      LOCKED:  if (!d_lock) state_next = OPEN;
      default: state_next = OPEN;
    endcase
  end

  prio_starve_arb #(
    .MAX_STARVE (MAX_STARVE)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .c_valid (c_valid),
    .d_valid (d_valid),
    .force_d (state == LOCKED),
    .clear   (state_next != state),
    .gnt_c   (gnt_c),
    .gnt_d   (gnt_d)
  );

  assign c_ready   = gnt_c;
  assign d_ready   = gnt_d;
  assign cpu_stall = c_valid && !gnt_c;
  assign d_locked  = (state == LOCKED);

  assign c_req    = '{we: c_we, addr: c_addr, wdata: c_wdata};
  assign d_req    = '{we: d_we, addr: d_addr, wdata: d_wdata};
  assign sel_port = gnt_d ? ARB_PORT_D : ARB_PORT_C;

  // Drive the memory from the granted requester; an idle cycle presents all zeros
  always_comb begin
    mem_req = '0;
    if (gnt_c || gnt_d) begin
      mem_req = (sel_port == ARB_PORT_D) ? d_req : c_req;
    end
  end

  assign mem_we    = mem_req.we;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;

  // Capture read data at the end of the grant cycle; writes answer with zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rsp_q <= '0;
      d_rsp_q <= '0;
    end else begin
      c_rsp_q.valid <= gnt_c;
      d_rsp_q.valid <= gnt_d;
      if (gnt_c) c_rsp_q.rdata <= c_we ? '0 : mem_rdata;
      if (gnt_d) d_rsp_q.rdata <= d_we ? '0 : mem_rdata;
    end
  end

  assign c_rsp_valid = c_rsp_q.valid;
  assign c_rdata     = c_rsp_q.rdata;
  assign d_rsp_valid = d_rsp_q.valid;
  assign d_rdata     = d_rsp_q.rdata;

`ifdef DMEM_ARB_PERF_EN
  // Saturating counts of CPU stall cycles and debug grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_dgrant_cnt <= '0;
    end else begin
      if (cpu_stall && (perf_stall_cnt != '1))  perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (gnt_d && (perf_dgrant_cnt != '1))     perf_dgrant_cnt <= perf_dgrant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with response scoreboard
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_valid, c_ready, c_we, c_rsp_valid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_valid, d_ready, d_we, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_lock, d_locked, cpu_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_dgrant_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] mem [0:255];
  logic [31:0] shadow [0:255];
  logic [31:0] c_q [$];
  logic [31:0] d_q [$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_rsp_valid (c_rsp_valid),
    .c_rdata     (c_rdata),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rdata     (d_rdata),
    .d_lock      (d_lock),
    .d_locked    (d_locked),
    .cpu_stall   (cpu_stall),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_dgrant_cnt (perf_dgrant_cnt)
`endif
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Scoreboard: compare responses against queued expectations, then queue newly accepted requests
  always @(negedge clk) begin
    if (rst_n) begin
      if (c_rsp_valid) begin
        total_cnt++;
        if (c_q.size() == 0) $display("FAIL c_rsp_unexpected: got rdata=%h, required no response", c_rdata);
        else begin
          logic [31:0] e;
          e = c_q.pop_front();
          if (c_rdata !== e) $display("FAIL c_rsp_data: got %h, required %h", c_rdata, e);
          else pass_cnt++;
        end
      end
      if (d_rsp_valid) begin
        total_cnt++;
        if (d_q.size() == 0) $display("FAIL d_rsp_unexpected: got rdata=%h, required no response", d_rdata);
        else begin
          logic [31:0] e;
          e = d_q.pop_front();
          if (d_rdata !== e) $display("FAIL d_rsp_data: got %h, required %h", d_rdata, e);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (c_rsp_valid && d_rsp_valid) $display("FAIL rsp_exclusive: got both rsp_valid=1, required at most one");
      else pass_cnt++;
      if (c_valid && c_ready) begin
        c_q.push_back(c_we ? 32'h0 : shadow[c_addr[9:2]]);
        if (c_we) shadow[c_addr[9:2]] = c_wdata;
      end
      if (d_valid && d_ready) begin
        d_q.push_back(d_we ? 32'h0 : shadow[d_addr[9:2]]);
        if (d_we) shadow[d_addr[9:2]] = d_wdata;
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    c_valid = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_lock  = 0;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    mem[addr[9:2]]    = data;
    shadow[addr[9:2]] = data;
  endtask

  task automatic test_reset;
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    total_cnt += 7;
    if (c_rsp_valid !== 1'b0) $display("FAIL reset_c_rsp_valid: got %b, required 0", c_rsp_valid); else pass_cnt++;
    if (d_rsp_valid !== 1'b0) $display("FAIL reset_d_rsp_valid: got %b, required 0", d_rsp_valid); else pass_cnt++;
    if (c_rdata !== 32'h0) $display("FAIL reset_c_rdata: got %h, required 0", c_rdata); else pass_cnt++;
    if (d_rdata !== 32'h0) $display("FAIL reset_d_rdata: got %h, required 0", d_rdata); else pass_cnt++;
    if (d_locked !== 1'b0) $display("FAIL reset_d_locked: got %b, required 0", d_locked); else pass_cnt++;
    if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b, required 0", mem_we); else pass_cnt++;
    if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); else pass_cnt++;
    next_cycle();
    rst_n = 1;
  endtask

  task automatic test_c_read;
    preload(32'h10, 32'hDEADBEEF);
    next_cycle();
    c_valid = 1; c_we = 0; c_addr = 32'h10;
    @(negedge clk);
    total_cnt += 3;
    if (c_ready !== 1'b1) $display("FAIL c_read_ready: got %b, required 1", c_ready); else pass_cnt++;
    if (cpu_stall !== 1'b0) $display("FAIL c_read_stall: got %b, required 0", cpu_stall); else pass_cnt++;
    if (mem_addr !== 32'h10) $display("FAIL c_read_mem_addr: got %h, required 00000010", mem_addr); else pass_cnt++;
    next_cycle();
    c_valid = 0;
    @(negedge clk);
    total_cnt += 2;
    if (c_rsp_valid !== 1'b1) $display("FAIL c_read_rsp_valid: got %b, required 1", c_rsp_valid); else pass_cnt++;
    if (c_rdata !== 32'hDEADBEEF) $display("FAIL c_read_rdata: got %h, required deadbeef", c_rdata); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (c_rsp_valid !== 1'b0) $display("FAIL c_read_rsp_pulse: got %b, required 0", c_rsp_valid); else pass_cnt++;
  endtask

  task automatic test_starvation;
    logic [5:0] exp_d;
    exp_d = 6'b010000;
    preload(32'h40, 32'hA5A5_0040);
    preload(32'h44, 32'h5A5A_0044);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      c_valid = 1; c_we = 0; c_addr = 32'h40;
      d_valid = 1; d_we = 0; d_addr = 32'h44;
      @(negedge clk);
      total_cnt += 3;
      if (c_ready !== !exp_d[i]) $display("FAIL starve_c_ready[%0d]: got %b, required %b", i, c_ready, !exp_d[i]); else pass_cnt++;
      if (d_ready !== exp_d[i]) $display("FAIL starve_d_ready[%0d]: got %b, required %b", i, d_ready, exp_d[i]); else pass_cnt++;
      if (cpu_stall !== exp_d[i]) $display("FAIL starve_stall[%0d]: got %b, required %b", i, cpu_stall, exp_d[i]); else pass_cnt++;
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_lock;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      c_valid = (i < 6); c_we = 0; c_addr = 32'h40;
      d_lock  = (i < 4);
      d_valid = (i == 2); d_we = 0; d_addr = 32'h44;
      @(negedge clk);
      total_cnt += 3;
      if (i == 0 || i == 5) begin
        if (c_ready !== 1'b1) $display("FAIL lock_c_ready[%0d]: got %b, required 1", i, c_ready); else pass_cnt++;
        if (cpu_stall !== 1'b0) $display("FAIL lock_stall[%0d]: got %b, required 0", i, cpu_stall); else pass_cnt++;
        if (d_locked !== 1'b0) $display("FAIL lock_d_locked[%0d]: got %b, required 0", i, d_locked); else pass_cnt++;
      end else begin
        if (c_ready !== 1'b0) $display("FAIL lock_c_ready[%0d]: got %b, required 0", i, c_ready); else pass_cnt++;
        if (cpu_stall !== 1'b1) $display("FAIL lock_stall[%0d]: got %b, required 1", i, cpu_stall); else pass_cnt++;
        if (d_locked !== 1'b1) $display("FAIL lock_d_locked[%0d]: got %b, required 1", i, d_locked); else pass_cnt++;
      end
      if (i == 2) begin
        total_cnt++;
        if (d_ready !== 1'b1) $display("FAIL lock_d_ready: got %b, required 1", d_ready); else pass_cnt++;
      end
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_d_write_c_read;
    next_cycle();
    d_valid = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    @(negedge clk);
    total_cnt += 2;
    if (d_ready !== 1'b1) $display("FAIL dw_d_ready: got %b, required 1", d_ready); else pass_cnt++;
    if (mem_we !== 1'b1) $display("FAIL dw_mem_we: got %b, required 1", mem_we); else pass_cnt++;
    next_cycle();
    d_valid = 0; d_we = 0;
    c_valid = 1; c_we = 0; c_addr = 32'h20;
    @(negedge clk);
    total_cnt += 2;
    if (d_rsp_valid !== 1'b1 || d_rdata !== 32'h0) $display("FAIL dw_d_rsp: got valid=%b rdata=%h, required valid=1 rdata=0", d_rsp_valid, d_rdata); else pass_cnt++;
    if (mem_we !== 1'b0) $display("FAIL cr_mem_we: got %b, required 0", mem_we); else pass_cnt++;
    next_cycle();
    c_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (c_rsp_valid !== 1'b1 || c_rdata !== 32'h12345678) $display("FAIL cr_c_rsp: got valid=%b rdata=%h, required valid=1 rdata=12345678", c_rsp_valid, c_rdata); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_mid;
    next_cycle();
    c_valid = 1; c_we = 0; c_addr = 32'h10;
    @(negedge clk);
    total_cnt++;
    if (c_ready !== 1'b1) $display("FAIL rstmid_c_ready: got %b, required 1", c_ready); else pass_cnt++;
    next_cycle();
    rst_n = 0;
    idle_inputs();
    c_q.delete();
    d_q.delete();
    @(negedge clk);
    total_cnt += 3;
    if (c_rsp_valid !== 1'b0) $display("FAIL rstmid_c_rsp_valid: got %b, required 0", c_rsp_valid); else pass_cnt++;
    if (c_rdata !== 32'h0) $display("FAIL rstmid_c_rdata: got %h, required 0", c_rdata); else pass_cnt++;
    if (d_locked !== 1'b0 || mem_we !== 1'b0) $display("FAIL rstmid_outputs: got d_locked=%b mem_we=%b, required 0 0", d_locked, mem_we); else pass_cnt++;
    next_cycle();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (c_rsp_valid !== 1'b0) $display("FAIL rstmid_no_rsp[%0d]: got %b, required 0", i, c_rsp_valid); else pass_cnt++;
      next_cycle();
    end
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic test_perf;
    next_cycle();
    d_valid = 1; d_we = 0; d_addr = 32'h44;
    next_cycle();
    d_valid = 0; c_valid = 1; c_addr = 32'h40; d_lock = 1;
    next_cycle();
    d_valid = 1;
    next_cycle();
    d_valid = 0;
    next_cycle();
    d_lock = 0;
    next_cycle();
    c_valid = 0;
    next_cycle();
    @(negedge clk);
    total_cnt += 2;
    if (perf_stall_cnt !== 32'd3) $display("FAIL perf_stall_cnt: got %0d, required 3", perf_stall_cnt); else pass_cnt++;
    if (perf_dgrant_cnt !== 32'd2) $display("FAIL perf_dgrant_cnt: got %0d, required 2", perf_dgrant_cnt); else pass_cnt++;
    next_cycle();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    test_reset();
    test_c_read();
    test_starvation();
    test_lock();
    test_d_write_c_read();
    test_reset_mid();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    next_cycle();
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (c_q.size() != 0 || d_q.size() != 0) $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", c_q.size(), d_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
